// File: rtl/dual_7_seg_decoder.sv
// rtl/dual_7_seg_decoder.sv - two-digit 7-segment readback decoder with stability filter
//
// Recovers the digit codes and the binary score from the tens/ones segment
// buses of the scoreboard encoder. A new pair of patterns must be held for
// STABLE_CYCLES consecutive matching samples before it is committed, so
// glitches and mid-transition patterns never reach the outputs.
//
// Parameters:
//   STABLE_CYCLES  consecutive identical samples required before commit (1..255)
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   seg_tens_i   tens segments {g,f,e,d,c,b,a}, 1 = lit
//   seg_ones_i   ones segments, same mapping
//   tens_o       committed tens code (0-9, 10 blank, 11 'P', 12 dash, 15 unknown)
//   ones_o       committed ones code
//   value_o      tens_o*10 + ones_o when num_valid_o, else 0
//   num_valid_o  both committed codes are decimal digits
//   err_o        at least one committed digit was not recognised
//   valid_o      one-cycle pulse when a commit changes the reading
module dual_7_seg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] seg_tens_i,
    input  logic [6:0] seg_ones_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic [6:0] value_o,
    output logic       num_valid_o,
    output logic       err_o,
    output logic       valid_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [3:0] CODE_BLANK   = 4'd10;
    localparam logic [3:0] CODE_P       = 4'd11;
    localparam logic [3:0] CODE_DASH    = 4'd12;
    localparam logic [3:0] CODE_UNKNOWN = 4'd15;

    // Returns {unknown_flag, code} for one digit's segment pattern.
    function automatic logic [4:0] decode_digit(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b0111111: r = {1'b0, 4'd0};
            7'b0000110: r = {1'b0, 4'd1};
            7'b1011011: r = {1'b0, 4'd2};
            7'b1001111: r = {1'b0, 4'd3};
            7'b1100110: r = {1'b0, 4'd4};
            7'b1101101: r = {1'b0, 4'd5};
            7'b1111101: r = {1'b0, 4'd6};
            7'b0000111: r = {1'b0, 4'd7};
            7'b1111111: r = {1'b0, 4'd8};
            7'b1101111: r = {1'b0, 4'd9};
            7'b0000000: r = {1'b0, CODE_BLANK};
            7'b1110011: r = {1'b0, CODE_P};
            7'b1000000: r = {1'b0, CODE_DASH};
            default:    r = {1'b1, CODE_UNKNOWN};
        endcase
        return r;
    endfunction

    // Filter state
    logic [13:0]      samp_q;
    logic [CNT_W-1:0] cnt_q;
    logic             first_q;

    // Candidate reading decoded straight from the live inputs; only ever
    // used on a commit edge, never driven to the outputs combinationally.
    logic [13:0] cur_bus;
    logic        match;
    logic        commit;
    logic [4:0]  dec_tens;
    logic [4:0]  dec_ones;
    logic        new_err;
    logic        new_num_valid;
    logic [6:0]  new_value;
    logic        reading_changed;

    assign cur_bus = {seg_tens_i, seg_ones_i};
    assign match   = (cur_bus == samp_q);

    // Fires only on the edge where the counter would reach STABLE_CYCLES,
    // so a long stable run commits exactly once and the saturated counter
    // keeps it from recommitting.
    assign commit  = match && (cnt_q == CNT_COMMIT);

    assign dec_tens = decode_digit(seg_tens_i);
    assign dec_ones = decode_digit(seg_ones_i);

    assign new_err       = dec_tens[4] | dec_ones[4];
    assign new_num_valid = (dec_tens[3:0] <= 4'd9) && (dec_ones[3:0] <= 4'd9);

    always_comb begin
        new_value = 7'd0;
        if (new_num_valid) begin
            new_value = 7'(dec_tens[3:0]) * 7'd10 + 7'(dec_ones[3:0]);
        end
    end

    // value_o and num_valid_o are functions of the codes, so comparing the
    // codes and the error flag is enough to detect a changed reading.
    assign reading_changed = ({dec_tens[3:0], dec_ones[3:0], new_err}
                              != {tens_o, ones_o, err_o});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            samp_q      <= 14'h0000;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            tens_o      <= 4'd0;
            ones_o      <= 4'd0;
            value_o     <= 7'd0;
            num_valid_o <= 1'b0;
            err_o       <= 1'b0;
            valid_o     <= 1'b0;
        end else begin
            samp_q <= cur_bus;

            if (!match) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            valid_o <= 1'b0;

            if (commit) begin
                tens_o      <= dec_tens[3:0];
                ones_o      <= dec_ones[3:0];
                err_o       <= new_err;
                num_valid_o <= new_num_valid;
                value_o     <= new_value;
                valid_o     <= first_q || reading_changed;
                first_q     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dual_7_seg_decoder.sv
// tb/tb_dual_7_seg_decoder.sv - scoreboard bench for dual_7_seg_decoder (STABLE_CYCLES 4 and 1)
module tb_dual_7_seg_decoder;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic [6:0] value;
        logic       nv;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_tens = 7'd0;
    logic [6:0] seg_ones = 7'd0;

    logic [3:0] tens_w  [2];
    logic [3:0] ones_w  [2];
    logic [6:0] value_w [2];
    logic       nv_w    [2];
    logic       err_w   [2];
    logic       valid_w [2];

    int checks = 0;
    int errors = 0;

    // Encoder patterns for codes 0..12 (index = code).
    logic [6:0] pats [13] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b0000000, 7'b1110011,
        7'b1000000
    };

    always #5 clk = ~clk;

    dual_7_seg_decoder #(.STABLE_CYCLES(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .seg_tens_i(seg_tens), .seg_ones_i(seg_ones),
        .tens_o(tens_w[0]), .ones_o(ones_w[0]), .value_o(value_w[0]),
        .num_valid_o(nv_w[0]), .err_o(err_w[0]), .valid_o(valid_w[0])
    );

    dual_7_seg_decoder #(.STABLE_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .seg_tens_i(seg_tens), .seg_ones_i(seg_ones),
        .tens_o(tens_w[1]), .ones_o(ones_w[1]), .value_o(value_w[1]),
        .num_valid_o(nv_w[1]), .err_o(err_w[1]), .valid_o(valid_w[1])
    );

    function automatic int ref_code(input logic [6:0] seg);
        for (int i = 0; i < 13; i++) begin
            if (pats[i] == seg) return i;
        end
        return 15;
    endfunction

    function automatic exp_t ref_reading(input logic [13:0] bus);
        exp_t r;
        int t;
        int o;
        t = ref_code(bus[13:7]);
        o = ref_code(bus[6:0]);
        r.tens  = 4'(t);
        r.ones  = 4'(o);
        r.err   = (t == 15) || (o == 15);
        r.nv    = (t < 10) && (o < 10);
        r.value = r.nv ? 7'(t * 10 + o) : 7'd0;
        return r;
    endfunction

    // Per-DUT reference model and monitor.
    for (genvar g = 0; g < 2; g++) begin : m
        localparam int S = (g == 0) ? 4 : 1;
        logic [13:0] hist [$];
        exp_t        q [$];
        exp_t        held = '0;
        bit          first = 1'b1;

        // A reading commits on the edge where the last S+1 samples (the
        // reset state counting as one zero sample) are identical and the
        // sample before that window differed or did not exist.
        always @(posedge clk) begin : model
            exp_t        n;
            bit          stable;
            logic [13:0] cur;
            if (rst) begin
                hist.delete();
                hist.push_back(14'h0);
                first = 1'b1;
                held  = '0;
            end else begin
                cur = {seg_tens, seg_ones};
                hist.push_back(cur);
                if (hist.size() > S + 2) hist.delete(0);
                if (hist.size() >= S + 1) begin
                    stable = 1'b1;
                    for (int i = hist.size() - S - 1; i < hist.size(); i++) begin
                        if (hist[i] != cur) stable = 1'b0;
                    end
                    if (stable && (hist.size() == S + 1 || hist[0] != cur)) begin
                        n = ref_reading(cur);
                        if (first || n.tens != held.tens || n.ones != held.ones || n.err != held.err)
                            q.push_back(n);
                        held  = n;
                        first = 1'b0;
                    end
                end
            end
        end

        always @(posedge clk) begin : monitor
            exp_t act;
            exp_t e;
            #1;
            act = {tens_w[g], ones_w[g], value_w[g], nv_w[g], err_w[g]};
            checks++;
            if (act !== held) begin
                errors++;
                $display("FAIL hold_s%0d t=%0t actual=%h expected=%h", S, $time, act, held);
            end
            if (valid_w[g]) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse_s%0d t=%0t actual=%h", S, $time, act);
                end else begin
                    e = q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL pulse_data_s%0d t=%0t actual=%h expected=%h", S, $time, act, e);
                    end
                end
            end else if (q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse_s%0d t=%0t actual=%h expected=%h", S, $time, act, q[0]);
                q.delete();
            end
        end
    end

    task automatic hold(input logic [6:0] t, input logic [6:0] o, input int n);
        seg_tens = t;
        seg_ones = o;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({tens_w[d], ones_w[d], value_w[d], nv_w[d], err_w[d], valid_w[d]} !== 19'h0) begin
                errors++;
                $display("FAIL %s dut%0d actual=%h required=0", name, d,
                         {tens_w[d], ones_w[d], value_w[d], nv_w[d], err_w[d], valid_w[d]});
            end
        end
    endtask

    function automatic logic [6:0] rand_seg();
        logic [6:0] s;
        if ($urandom_range(0, 9) < 7) s = pats[$urandom_range(0, 12)];
        else s = 7'($urandom);
        return s;
    endfunction

    initial begin
        // Reset state with blank inputs
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;

        hold(7'b0000000, 7'b0000000, 8);          // blank commits once after release
        hold(7'b1100110, 7'b1011011, 10);         // "42"
        hold(7'b1100110, 7'b0000111, 2);          // ones briefly "7"
        hold(7'b1100110, 7'b1011011, 6);          // back to "42"
        hold(7'b1101111, 7'b1101111, 8);          // "99"
        hold(7'b0000001, 7'b0111111, 8);          // unknown tens
        hold(7'b1110011, 7'b1000000, 8);          // "P" dash
        hold(7'b1101101, 7'b1101101, 8);          // "55"
        hold(7'b1101101, 7'b1101101, 2);

        // Mid-run reset: outputs clear before the next edge
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        hold(7'b1101101, 7'b1101101, 8);

        // Encoder output sweep, codes 12..15 all drive the dash pattern
        for (int c = 0; c < 16; c++) begin
            hold(pats[(c <= 11) ? c : 12], pats[(15 - c <= 11) ? 15 - c : 12], 3);
        end

        // Randomised runs, glitches and occasional resets
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            hold(rand_seg(), rand_seg(), $urandom_range(1, 7));
        end

        hold(7'b0000110, 7'b0111111, 10);         // "10" to finish on a settled reading

        checks++;
        if (m[0].q.size() != 0) begin
            errors++;
            $display("FAIL drain_s4 actual=%0d required=0", m[0].q.size());
        end
        checks++;
        if (m[1].q.size() != 0) begin
            errors++;
            $display("FAIL drain_s1 actual=%0d required=0", m[1].q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
